// File: rtl/window_3x3_gen_if.sv
// Pixel-stream / 3x3 window bundle for window_3x3_gen.
// The master side drives pixels and receives the taps; the slave side is the window generator.
interface window_3x3_gen_if;
    logic       iDVAL, iSOF;
    logic [7:0] iR, iG, iB;
    logic [7:0] oR00, oR01, oR02, oR10, oR11, oR12, oR20, oR21, oR22;
    logic [7:0] oG00, oG01, oG02, oG10, oG11, oG12, oG20, oG21, oG22;
    logic [7:0] oB00, oB01, oB02, oB10, oB11, oB12, oB20, oB21, oB22;
    logic       oDVAL;
    logic [15:0] oX, oY;

    modport master (
        output iDVAL, iSOF, iR, iG, iB,
        input  oR00, oR01, oR02, oR10, oR11, oR12, oR20, oR21, oR22,
        input  oG00, oG01, oG02, oG10, oG11, oG12, oG20, oG21, oG22,
        input  oB00, oB01, oB02, oB10, oB11, oB12, oB20, oB21, oB22,
        input  oDVAL, oX, oY
    );

    modport slave (
        input  iDVAL, iSOF, iR, iG, iB,
        output oR00, oR01, oR02, oR10, oR11, oR12, oR20, oR21, oR22,
        output oG00, oG01, oG02, oG10, oG11, oG12, oG20, oG21, oG22,
        output oB00, oB01, oB02, oB10, oB11, oB12, oB20, oB21, oB22,
        output oDVAL, oX, oY
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster RGB stream -> registered 3x3 neighbourhood, latency 1, two line buffers + column shift.
// Optional macro EDGE_REPLICATE_EN: out-of-frame taps copy their in-frame neighbour instead of 0.
module window_3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic             iCLK,
    input logic             iRST_N,
    window_3x3_gen_if.slave bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
`ifdef EDGE_REPLICATE_EN
    localparam bit EdgeRepl = 1'b1;
`else
    localparam bit EdgeRepl = 1'b0;
`endif

    function automatic logic [23:0] edgeFill(input logic [23:0] nb);
        return EdgeRepl ? nb : 24'd0;
    endfunction

    logic [15:0]   xCnt, yCnt, curX, curY, nxtX, nxtY;
    logic          accept, winVld_p0, vld_p1;
    logic [AW-1:0] addr;
    logic [23:0]   pix_p0, rdA_p0, rdB_p0;
    logic [23:0]   lineA [IMG_W];
    logic [23:0]   lineB [IMG_W];
    logic [23:0]   col1 [3];
    logic [23:0]   col0 [3];
    logic [23:0]   newCol_p0 [3];
    logic [23:0]   win_p0 [3][3];
    logic [23:0]   tap_p1 [3][3];
    logic [15:0]   outX_p1, outY_p1;

    // Stage p0: locate the accepted pixel, read both line buffers, assemble the masked window
    always_comb begin
        accept    = bus.iDVAL;
        curX      = bus.iSOF ? 16'd0 : xCnt;
        curY      = bus.iSOF ? 16'd0 : yCnt;
        nxtX      = (curX == 16'(IMG_W - 1)) ? 16'd0 : curX + 16'd1;
        nxtY      = curY;
        if (curX == 16'(IMG_W - 1))
            nxtY  = (curY == 16'(IMG_H - 1)) ? 16'd0 : curY + 16'd1;
        winVld_p0 = accept && (curX != 16'd0) && (curY != 16'd0);
        addr      = curX[AW-1:0];
        pix_p0    = {bus.iR, bus.iG, bus.iB};
        rdA_p0    = lineA[addr];
        rdB_p0    = lineB[addr];
        newCol_p0[0] = rdB_p0;
        newCol_p0[1] = rdA_p0;
        newCol_p0[2] = pix_p0;
        for (int r = 0; r < 3; r++) begin
            win_p0[r][0] = col0[r];
            win_p0[r][1] = col1[r];
            win_p0[r][2] = newCol_p0[r];
        end
        // Column first, then row: the corner then inherits tap 11 through tap 10.
        if (curX == 16'd1)
            for (int r = 0; r < 3; r++) win_p0[r][0] = edgeFill(win_p0[r][1]);
        if (curY == 16'd1)
            for (int c = 0; c < 3; c++) win_p0[0][c] = edgeFill(win_p0[1][c]);
    end

    // Line buffers hold no reset: every word is rewritten before it can reach an in-frame tap.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            lineA[addr] <= pix_p0;
            lineB[addr] <= rdA_p0;
        end
    end

    // Stage p1: registered window, coordinates and valid
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            xCnt    <= '0;
            yCnt    <= '0;
            vld_p1  <= 1'b0;
            outX_p1 <= '0;
            outY_p1 <= '0;
            for (int r = 0; r < 3; r++) begin
                col0[r] <= '0;
                col1[r] <= '0;
                for (int c = 0; c < 3; c++) tap_p1[r][c] <= '0;
            end
        end else begin
            vld_p1 <= winVld_p0;
            if (accept) begin
                xCnt <= nxtX;
                yCnt <= nxtY;
                for (int r = 0; r < 3; r++) begin
                    col0[r] <= col1[r];
                    col1[r] <= newCol_p0[r];
                end
            end
            if (winVld_p0) begin
                outX_p1 <= curX - 16'd1;
                outY_p1 <= curY - 16'd1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) tap_p1[r][c] <= win_p0[r][c];
            end
        end
    end

    assign bus.oDVAL = vld_p1;
    assign bus.oX    = outX_p1;
    assign bus.oY    = outY_p1;

    assign bus.oR00 = tap_p1[0][0][23:16]; assign bus.oG00 = tap_p1[0][0][15:8]; assign bus.oB00 = tap_p1[0][0][7:0];
    assign bus.oR01 = tap_p1[0][1][23:16]; assign bus.oG01 = tap_p1[0][1][15:8]; assign bus.oB01 = tap_p1[0][1][7:0];
    assign bus.oR02 = tap_p1[0][2][23:16]; assign bus.oG02 = tap_p1[0][2][15:8]; assign bus.oB02 = tap_p1[0][2][7:0];
    assign bus.oR10 = tap_p1[1][0][23:16]; assign bus.oG10 = tap_p1[1][0][15:8]; assign bus.oB10 = tap_p1[1][0][7:0];
    assign bus.oR11 = tap_p1[1][1][23:16]; assign bus.oG11 = tap_p1[1][1][15:8]; assign bus.oB11 = tap_p1[1][1][7:0];
    assign bus.oR12 = tap_p1[1][2][23:16]; assign bus.oG12 = tap_p1[1][2][15:8]; assign bus.oB12 = tap_p1[1][2][7:0];
    assign bus.oR20 = tap_p1[2][0][23:16]; assign bus.oG20 = tap_p1[2][0][15:8]; assign bus.oB20 = tap_p1[2][0][7:0];
    assign bus.oR21 = tap_p1[2][1][23:16]; assign bus.oG21 = tap_p1[2][1][15:8]; assign bus.oB21 = tap_p1[2][1][7:0];
    assign bus.oR22 = tap_p1[2][2][23:16]; assign bus.oG22 = tap_p1[2][2][15:8]; assign bus.oB22 = tap_p1[2][2][7:0];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen (IMG_W=4, IMG_H=3) against a frame-image reference model.
module tb_window_3x3_gen;
    localparam int W = 4;
    localparam int H = 3;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    window_3x3_gen_if bus ();
    window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (.iCLK(clk), .iRST_N(rstN), .bus(bus));

    int nAssert = 0;
    int nFail   = 0;
    int mx = 0, my = 0, ecx = 0, ecy = 0;
    logic [23:0] img [H][W];
    logic [15:0] pulseQ [$];

    function automatic logic [23:0] pat(input int x, input int y);
        logic [7:0] r;
        r = 8'(16 * y + x);
        return {r, ~r, 8'(x ^ y)};
    endfunction

    // Expected tap straight from frame coordinates; out-of-frame positions clamp or zero.
    function automatic logic [23:0] refTap(input int cx, input int cy, input int r, input int c);
        int px, py;
        px = cx - 1 + c;
        py = cy - 1 + r;
        if (px < 0 || py < 0) begin
`ifdef EDGE_REPLICATE_EN
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            return img[py][px];
`else
            return 24'd0;
`endif
        end
        return img[py][px];
    endfunction

    function automatic logic [23:0] obsTap(input int r, input int c);
        case (r * 3 + c)
            0: return {bus.oR00, bus.oG00, bus.oB00};
            1: return {bus.oR01, bus.oG01, bus.oB01};
            2: return {bus.oR02, bus.oG02, bus.oB02};
            3: return {bus.oR10, bus.oG10, bus.oB10};
            4: return {bus.oR11, bus.oG11, bus.oB11};
            5: return {bus.oR12, bus.oG12, bus.oB12};
            6: return {bus.oR20, bus.oG20, bus.oB20};
            7: return {bus.oR21, bus.oG21, bus.oB21};
            default: return {bus.oR22, bus.oG22, bus.oB22};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_oDVAL"}, 32'(bus.oDVAL), 32'd0);
        check({tag, "_oX"}, 32'(bus.oX), 32'd0);
        check({tag, "_oY"}, 32'(bus.oY), 32'd0);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_tap%0d%0d", tag, k / 3, k % 3), 32'(obsTap(k / 3, k % 3)), 32'd0);
    endtask

    // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input bit dv, input bit sof, input logic [23:0] pix);
        int ax, ay;
        bit ev;
        bus.iDVAL = dv;
        bus.iSOF  = sof;
        {bus.iR, bus.iG, bus.iB} = pix;
        ev = 1'b0;
        if (dv) begin
            ax = sof ? 0 : mx;
            ay = sof ? 0 : my;
            img[ay][ax] = pix;
            ev = (ax >= 1) && (ay >= 1);
            if (ev) begin
                ecx = ax - 1;
                ecy = ay - 1;
            end
            mx = (ax == W - 1) ? 0 : ax + 1;
            my = (ax == W - 1) ? ((ay == H - 1) ? 0 : ay + 1) : ay;
        end
        @(posedge clk);
        #1;
        check("oDVAL", 32'(bus.oDVAL), 32'(ev));
        if (bus.oDVAL === 1'b1) pulseQ.push_back({bus.oX[7:0], bus.oY[7:0]});
        if (ev) begin
            check("oX", 32'(bus.oX), 32'(ecx));
            check("oY", 32'(bus.oY), 32'(ecy));
            for (int k = 0; k < 9; k++)
                check($sformatf("win(%0d,%0d)_tap%0d%0d", ecx, ecy, k / 3, k % 3),
                      32'(obsTap(k / 3, k % 3)), 32'(refTap(ecx, ecy, k / 3, k % 3)));
        end
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
    endtask

    initial begin
        logic [7:0]  expMid [9];
        logic [7:0]  expBorder [9];
        logic [15:0] expPulse [6];
        logic [23:0] t;
        int guard;

        expMid = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
`ifdef EDGE_REPLICATE_EN
        expBorder = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11};
`else
        expBorder = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11};
`endif
        expPulse = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101, 16'h0201};

        rstN = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
        {bus.iR, bus.iG, bus.iB} = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset");
        @(negedge clk) rstN = 1'b1;

        // Gap-free pattern frame with the directed tap checks
        pulseQ.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                step(1'b1, (x == 0 && y == 0), pat(x, y));
                for (int k = 0; k < 9; k++) begin
                    t = obsTap(k / 3, k % 3);
                    if (x == 1 && y == 1)
                        check($sformatf("border_oR%0d%0d", k / 3, k % 3), 32'(t[23:16]), 32'(expBorder[k]));
                    if (x == 2 && y == 2)
                        check($sformatf("mid_oR%0d%0d", k / 3, k % 3), 32'(t[23:16]), 32'(expMid[k]));
                end
            end
        end
        check("pulseCount", 32'(pulseQ.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("pulse%0d_xy", k),
                  32'((k < pulseQ.size()) ? pulseQ[k] : 16'hFFFF), 32'(expPulse[k]));
        step(1'b0, 1'b0, 24'hABCDEF);

        // Same pattern frame with random idle cycles between pixels
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                repeat ($urandom_range(2, 0)) step(1'b0, 1'b0, 24'($urandom));
                step(1'b1, (x == 0 && y == 0), pat(x, y));
            end
        end

        // Frame aborted by iSOF at pixel (2,1); random data exposes any stale leakage
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0), 24'($urandom));
        step(1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < W * H + W; i++) begin
            if ($urandom_range(1, 0) == 1) step(1'b0, 1'b0, 24'($urandom));
            step(1'b1, 1'b0, 24'($urandom));
        end

        // Asynchronous reset right after an emitted window
        guard = 0;
        do begin
            step(1'b1, 1'b0, 24'($urandom));
            guard++;
        end while (bus.oDVAL !== 1'b1 && guard < 2 * W * H);
        check("preReset_oDVAL", 32'(bus.oDVAL), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkZero("asyncReset");
        @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        mx = 0;
        my = 0;

        // Restart without iSOF: counters came out of reset at (0,0)
        for (int i = 0; i < 2 * W * H; i++) begin
            if ($urandom_range(1, 0) == 1) step(1'b0, 1'b0, 24'($urandom));
            step(1'b1, 1'b0, 24'($urandom));
        end
        step(1'b0, 1'b0, 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
